// File: rtl/topk_frame_sorter.sv
// Per-frame top-K tracker: keeps the K largest samples in a descending register list,
// snapshots the list at frame end and streams it out over a valid/ready read port.
module topk_frame_sorter #(
  parameter int W = 12,
  parameter int K = 16,
  localparam int SW = $clog2(K),
  localparam int CW = $clog2(K+1),
  localparam int IW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          FrameStart,
  input  logic          FrameEnd,
  input  logic          DataEn,
  input  logic [W-1:0]  DataIn,
  output logic [W-1:0]  DataMax,
  output logic [W-1:0]  DataKth,
  output logic [W+SW-1:0] DataSumOut,
  output logic [CW-1:0] Count,
  output logic          ResValid,
  output logic [W-1:0]  ResMax,
  output logic [W+SW-1:0] ResSum,
  output logic [CW-1:0] ResCount,
  output logic          RdValid,
  input  logic          RdReady,
  output logic [W-1:0]  RdData,
  output logic [IW-1:0] RdIdx,
  output logic          Busy,
  output logic          ErrFrameDrop
);

  // Read port: RdValid/RdData/RdIdx form one beat; a beat is consumed on a cycle
  // where RdValid & RdReady, and RdData/RdIdx stay stable while RdValid & !RdReady.
  typedef enum logic {ST_IDLE = 1'b0, ST_DUMP = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_e [K];
  logic [K-1:0]    r_v;
  logic [W+SW-1:0] r_sum;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_snap [K];
  logic [W+SW-1:0] r_res_sum;
  logic [CW-1:0]   r_res_count;
  logic            r_res_valid;
  logic [IW-1:0]   r_idx;
  logic            r_err;

  logic [W-1:0]    w_base_e [K];
  logic [K-1:0]    w_base_v;
  logic [W+SW-1:0] w_base_sum;
  logic [CW-1:0]   w_base_count;
  logic [K-1:0]    w_ge;
  logic            w_full, w_ins;
  logic [W-1:0]    w_e_nxt [K];
  logic [K-1:0]    w_v_nxt;
  logic [W+SW-1:0] w_sum_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_src_count;
  logic            w_accept_end, w_last;
  logic [IW-1:0]   w_kth_idx;

  // FrameStart empties the list before the same-cycle sample is inserted.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_base_e[i] = FrameStart ? '0 : r_e[i];
    end
    w_base_v     = FrameStart ? '0 : r_v;
    w_base_sum   = FrameStart ? '0 : r_sum;
    w_base_count = FrameStart ? '0 : r_count;
    for (int i = 0; i < K; i++) begin
      w_ge[i] = w_base_v[i] && (w_base_e[i] >= DataIn);
    end
    w_full = w_base_v[K-1];
    w_ins  = DataEn && !w_ge[K-1];
  end

  // w_ge is a prefix mask; the first clear bit is the insert slot, later slots shift down.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_e_nxt[i] = w_base_e[i];
    end
    w_v_nxt     = w_base_v;
    w_sum_nxt   = w_base_sum;
    w_count_nxt = w_base_count;
    if (w_ins) begin
      if (!w_ge[0]) begin
        w_e_nxt[0] = DataIn;
        w_v_nxt[0] = 1'b1;
      end
      for (int i = 1; i < K; i++) begin
        if (!w_ge[i]) begin
          w_e_nxt[i] = w_ge[i-1] ? DataIn : w_base_e[i-1];
          w_v_nxt[i] = w_base_v[i-1];
        end
      end
      w_sum_nxt = w_base_sum + (W+SW)'(DataIn)
                - (w_full ? (W+SW)'(w_base_e[K-1]) : '0);
      w_count_nxt = w_base_count + (w_full ? CW'(0) : CW'(1));
    end
  end

  assign w_accept_end = FrameEnd && (r_state == ST_IDLE);
  // With FrameStart also high the closing frame is the pre-insertion list.
  assign w_src_count  = FrameStart ? r_count : w_count_nxt;
  assign w_last       = (CW'(r_idx) == (r_res_count - CW'(1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (FrameEnd && (w_src_count != '0)) w_state_nxt = ST_DUMP;
      ST_DUMP: if (RdReady && w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < K; i++) begin
        r_e[i] <= '0;
      end
      r_v     <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < K; i++) begin
        r_e[i] <= w_e_nxt[i];
      end
      r_v     <= w_v_nxt;
      r_sum   <= w_sum_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < K; i++) begin
        r_snap[i] <= '0;
      end
      r_res_sum   <= '0;
      r_res_count <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_accept_end;
      if (w_accept_end) begin
        for (int i = 0; i < K; i++) begin
          r_snap[i] <= FrameStart ? r_e[i] : w_e_nxt[i];
        end
        r_res_sum   <= FrameStart ? r_sum : w_sum_nxt;
        r_res_count <= w_src_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_end) begin
        r_idx <= '0;
      end else if ((r_state == ST_DUMP) && RdReady) begin
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
      if (FrameEnd && (r_state == ST_DUMP)) begin
        r_err <= 1'b1;
      end else if (FrameStart) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_kth_idx    = IW'(r_count - CW'(1));
  assign DataMax      = r_e[0];
  assign DataKth      = (r_count == '0) ? '0 : r_e[w_kth_idx];
  assign DataSumOut   = r_sum;
  assign Count        = r_count;
  assign ResValid     = r_res_valid;
  assign ResMax       = r_snap[0];
  assign ResSum       = r_res_sum;
  assign ResCount     = r_res_count;
  assign RdValid      = (r_state == ST_DUMP);
  assign Busy         = (r_state == ST_DUMP);
  assign RdData       = RdValid ? r_snap[r_idx] : '0;
  assign RdIdx        = r_idx;
  assign ErrFrameDrop = r_err;

endmodule

// File: tb/tb_topk_frame_sorter.sv
// Bench for topk_frame_sorter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_topk_frame_sorter;
  localparam int W  = 12;
  localparam int K  = 16;
  localparam int SW = $clog2(K);
  localparam int CW = $clog2(K+1);
  localparam int IW = $clog2(K);

  logic            clk = 1'b0;
  logic            rst_x = 1'b1;
  logic            FrameStart = 1'b0, FrameEnd = 1'b0, DataEn = 1'b0, RdReady = 1'b1;
  logic [W-1:0]    DataIn = '0;
  logic [W-1:0]    DataMax, DataKth, ResMax, RdData;
  logic [W+SW-1:0] DataSumOut, ResSum;
  logic [CW-1:0]   Count, ResCount;
  logic            ResValid, RdValid, Busy, ErrFrameDrop;
  logic [IW-1:0]   RdIdx;

  topk_frame_sorter #(.W(W), .K(K)) dut (
    .clk(clk), .rst_x(rst_x), .FrameStart(FrameStart), .FrameEnd(FrameEnd),
    .DataEn(DataEn), .DataIn(DataIn), .DataMax(DataMax), .DataKth(DataKth),
    .DataSumOut(DataSumOut), .Count(Count), .ResValid(ResValid), .ResMax(ResMax),
    .ResSum(ResSum), .ResCount(ResCount), .RdValid(RdValid), .RdReady(RdReady),
    .RdData(RdData), .RdIdx(RdIdx), .Busy(Busy), .ErrFrameDrop(ErrFrameDrop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // ---------------- reference model ----------------
  int unsigned m_lst[$];
  int unsigned m_snap[$];
  int unsigned m_res_sum;
  bit          m_res_valid;
  bit          m_dump;
  int          m_idx;
  bit          m_err;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned qsum(input int unsigned q[$]);
    longint unsigned s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic void m_insert(input int unsigned x);
    int p = 0;
    foreach (m_lst[i]) if (m_lst[i] >= x) p++;
    if (p < K) begin
      m_lst.insert(p, x);
      if (m_lst.size() > K) void'(m_lst.pop_back());
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_x) begin
      m_lst.delete();
      m_snap.delete();
      m_res_sum = 0; m_res_valid = 0; m_dump = 0; m_idx = 0; m_err = 0;
    end else begin
      int unsigned pre[$];
      bit was_dump;
      pre = m_lst;
      was_dump = m_dump;
      if (FrameStart) begin
        m_lst.delete();
        m_err = 0;
      end
      if (DataEn) m_insert(DataIn);
      if (was_dump && RdReady) begin
        m_idx++;
        if (m_idx == m_snap.size()) begin
          m_dump = 0;
          m_idx  = 0;
        end
      end
      m_res_valid = 0;
      if (FrameEnd) begin
        if (was_dump) m_err = 1;
        else begin
          m_snap      = FrameStart ? pre : m_lst;
          m_res_sum   = int'(qsum(m_snap));
          m_res_valid = 1;
          m_dump      = (m_snap.size() > 0);
          m_idx       = 0;
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en && rst_x) begin
      chk("DataMax",    DataMax,    (m_lst.size() > 0) ? m_lst[0] : 0);
      chk("DataKth",    DataKth,    (m_lst.size() > 0) ? m_lst[m_lst.size()-1] : 0);
      chk("DataSumOut", DataSumOut, qsum(m_lst));
      chk("Count",      Count,      m_lst.size());
      chk("ResValid",   ResValid,   m_res_valid);
      chk("ResMax",     ResMax,     (m_snap.size() > 0) ? m_snap[0] : 0);
      chk("ResSum",     ResSum,     m_res_sum);
      chk("ResCount",   ResCount,   m_snap.size());
      chk("RdValid",    RdValid,    m_dump);
      chk("Busy",       Busy,       m_dump);
      chk("RdIdx",      RdIdx,      m_idx);
      chk("RdData",     RdData,     m_dump ? m_snap[m_idx] : 0);
      chk("ErrFrameDrop", ErrFrameDrop, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit fs, input bit fe, input bit den, input int din, input bit rdy);
    @(negedge clk);
    FrameStart = fs; FrameEnd = fe; DataEn = den; DataIn = W'(din); RdReady = rdy;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, rdy);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_x = 1'b0;
    #1;
    chk("rst_Count", Count, 0);
    chk("rst_DataMax", DataMax, 0);
    chk("rst_DataKth", DataKth, 0);
    chk("rst_DataSumOut", DataSumOut, 0);
    chk("rst_ResValid", ResValid, 0);
    chk("rst_ResMax", ResMax, 0);
    chk("rst_ResSum", ResSum, 0);
    chk("rst_ResCount", ResCount, 0);
    chk("rst_RdValid", RdValid, 0);
    chk("rst_Busy", Busy, 0);
    chk("rst_RdIdx", RdIdx, 0);
    chk("rst_RdData", RdData, 0);
    chk("rst_Err", ErrFrameDrop, 0);
    @(posedge clk);
    #2;
    rst_x = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;

    // 1..20 ascending keeps 5..20
    cyc(1, 0, 0, 0, 1);
    for (int v = 1; v <= 20; v++) cyc(0, 0, 1, v, 1);
    settle();
    chk("asc_Count", Count, 16);
    chk("asc_Max", DataMax, 20);
    chk("asc_Kth", DataKth, 5);
    chk("asc_Sum", DataSumOut, 200);

    // equal-to-Kth and smaller are rejected; a new max evicts 5
    cyc(0, 0, 1, 5, 1);
    cyc(0, 0, 1, 3, 1);
    settle();
    chk("rej_Sum", DataSumOut, 200);
    chk("rej_Kth", DataKth, 5);
    cyc(0, 0, 1, 4095, 1);
    settle();
    chk("big_Max", DataMax, 4095);
    chk("big_Kth", DataKth, 6);
    chk("big_Sum", DataSumOut, 4290);

    // all-max frame: sum at the top of its range, then a full dump
    cyc(1, 0, 1, 4095, 1);
    for (int i = 1; i < 16; i++) cyc(0, 0, 1, 4095, 1);
    settle();
    chk("sat_Sum", DataSumOut, 65520);
    cyc(0, 1, 0, 0, 1);
    settle();
    chk("sat_ResValid", ResValid, 1);
    chk("sat_ResSum", ResSum, 65520);
    chk("sat_ResCount", ResCount, 16);
    chk("sat_RdValid", RdValid, 1);
    for (int i = 0; i < 15; i++) idle(1);
    settle();
    chk("sat_lastValid", RdValid, 1);
    chk("sat_lastIdx", RdIdx, 15);
    idle(1);
    settle();
    chk("sat_endValid", RdValid, 0);

    // ties and a stalled beat
    cyc(1, 0, 1, 3, 1);
    cyc(0, 0, 1, 9, 1);
    cyc(0, 0, 1, 9, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 1);
    settle();
    chk("tie_ResValid", ResValid, 1);
    chk("tie_ResCount", ResCount, 4);
    chk("tie_ResMax", ResMax, 9);
    chk("tie_d0", RdData, 9);
    chk("tie_i0", RdIdx, 0);
    idle(1); settle();
    chk("tie_pulse", ResValid, 0);
    chk("tie_d1", RdData, 9);
    chk("tie_i1", RdIdx, 1);
    idle(0); settle();
    chk("tie_hold_d", RdData, 9);
    chk("tie_hold_i", RdIdx, 1);
    idle(1); settle();
    chk("tie_d2", RdData, 3);
    chk("tie_i2", RdIdx, 2);
    idle(1); settle();
    chk("tie_d3", RdData, 1);
    chk("tie_i3", RdIdx, 3);
    idle(1); settle();
    chk("tie_end", RdValid, 0);

    // FrameEnd during a dump is dropped and flagged
    cyc(1, 0, 1, 10, 1);
    cyc(0, 0, 1, 20, 1);
    cyc(0, 0, 1, 30, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    settle();
    chk("drop_Err", ErrFrameDrop, 1);
    chk("drop_ResValid", ResValid, 0);
    chk("drop_RdData", RdData, 30);
    chk("drop_ResCount", ResCount, 3);
    for (int i = 0; i < 3; i++) idle(1);
    cyc(1, 0, 0, 0, 1);
    settle();
    chk("drop_ErrClr", ErrFrameDrop, 0);
    chk("drop_done", RdValid, 0);

    // start+end+sample in one cycle: old list closes, sample opens new frame
    cyc(0, 0, 1, 50, 1);
    cyc(1, 1, 1, 77, 1);
    settle();
    chk("same_ResCount", ResCount, 1);
    chk("same_ResMax", ResMax, 50);
    chk("same_ResSum", ResSum, 50);
    chk("same_Count", Count, 1);
    chk("same_Max", DataMax, 77);
    chk("same_RdData", RdData, 50);
    idle(1); settle();
    chk("same_end", RdValid, 0);

    // empty frame: result pulse without readout
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    settle();
    chk("empty_ResValid", ResValid, 1);
    chk("empty_ResCount", ResCount, 0);
    chk("empty_RdValid", RdValid, 0);
    idle(1); settle();
    chk("empty_RdValid2", RdValid, 0);

    // reset in the middle of a dump
    cyc(1, 0, 1, 100, 1);
    cyc(0, 0, 1, 200, 1);
    cyc(0, 1, 0, 0, 0);
    idle(0);
    settle();
    chk("mid_RdValid", RdValid, 1);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit fs, fe, den, rdy;
      int din;
      fs  = ($urandom_range(0, 39) == 0);
      fe  = ($urandom_range(0, 29) == 0);
      den = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 3) != 0);
      din = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 4095);
      cyc(fs, fe, den, din, rdy);
    end
    for (int i = 0; i < 40; i++) idle(1);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/topk_frame_sorter.md
# topk_frame_sorter

Parametrised successor to the fixed 16-deep max-keeper. It tracks the K largest samples of a stream per frame in a sorted register array. It provides live max, K-th largest and running sum, and on frame end snapshots the sorted list and streams it out over a valid/ready port. It sits behind the sample source in the same slot as the 2-in-1 sort block and adds frame control, selectable depth and list readout.

## Interface
- W, 12, sample width (unsigned)
- K, 16, list depth, 2..64
- SW, $clog2(K), derived, sum growth bits
- CW, $clog2(K+1), derived, count width
- IW, $clog2(K), derived, readout index width
- clk  in  1  single clock, rising edge
- rst_x  in  1  reset, asynchronous, active-low
- FrameStart  in  1  clear list, begin new frame
- FrameEnd  in  1  close frame: snapshot and start dump
- DataEn  in  1  sample valid
- DataIn  in  W  sample
- DataMax  out  W  live largest held value, 0 when empty
- DataKth  out  W  live smallest held value, 0 when empty
- DataSumOut  out  W+SW  live sum of held values
- Count  out  CW  live number of held values, saturates at K
- ResValid  out  1  one-cycle pulse: Res* outputs updated
- ResMax  out  W  snapshot max
- ResSum  out  W+SW  snapshot sum
- ResCount  out  CW  snapshot count
- RdValid  out  1  readout entry valid
- RdReady  in  1  downstream accepts entry
- RdData  out  W  snapshot entry, descending order
- RdIdx  out  IW  rank of RdData, 0 = largest
- Busy  out  1  dump in progress
- ErrFrameDrop  out  1  sticky: FrameEnd ignored during dump; cleared by FrameStart

## Operation
- List: E[0..K-1] descending, per-entry valid bits, one sample accepted per cycle, no backpressure on DataIn.
- Insert position p = number of valid entries with E[i] >= DataIn. Ties place the new sample after equals.
- If p < K: write the sample at p, shift p..K-2 down one, and drop E[K-1] if the list was full.
- If p == K (full and DataIn <= E[K-1]): reject the sample, list unchanged.
- Sum update: sum_next = sum + DataIn - dropped, where dropped = E[K-1] only when full and inserted, else 0.
  - Width W+SW never overflows because max is K*(2^W-1).
- FrameStart: the list, sum and Count become empty/0. A DataEn in the same cycle is inserted into the emptied list and belongs to the new frame.
- FrameEnd (state IDLE): the snapshot takes the post-insertion list, including a same-cycle DataEn sample.
  - Exception: when FrameStart is also high, the snapshot takes the pre-insertion list and the sample goes to the new frame.
- States:
  - IDLE --FrameEnd & snapshot count>0--> DUMP
  - IDLE --FrameEnd & count==0--> IDLE (ResValid still pulses; no readout)
  - DUMP --last entry accepted--> IDLE
- DUMP:
  - RdValid=1, RdData=snap[RdIdx].
  - RdIdx increments on RdValid & RdReady.
  - When RdIdx==ResCount-1 is accepted, RdValid drops and the state returns to IDLE.
  - RdData/RdIdx hold stable while RdValid & !RdReady.
- Accumulation of the live list continues independently throughout DUMP. The snapshot is a separate K*W register bank.
- FrameEnd while in DUMP: ignored, snapshot untouched, ErrFrameDrop set.

## Timing
- Reset (rst_x low, asynchronous): all outputs 0, list empty, state IDLE, ErrFrameDrop 0.
- Live outputs are registered and reflect a DataEn sample the cycle after it is presented.
- FrameStart clear is visible the next cycle (Count=0, or 1 if DataEn was also high).
- FrameEnd at cycle t:
  - ResValid=1 at t+1 only.
  - Res* valid from t+1 and held until the next accepted FrameEnd.
  - RdValid and Busy rise at t+1.
- Readout throughput is one entry per cycle with RdReady held high. A dump of N entries ends with RdValid low at t+1+N.
- Busy equals RdValid.
- Reset asserted mid-dump aborts immediately; no partial state survives.

## Test plan
- W=12, K=16; reset then FrameStart; DataEn with 1..20 ascending -> Count=16, DataMax=20, DataKth=5, DataSumOut=200.
- Full list, then DataIn=5 (equal to Kth) and DataIn=3 -> both rejected, sum stays 200; then DataIn=4095 -> DataMax=4095, DataKth=6, sum=4290.
- 16 samples of 4095 -> DataSumOut=65520 (0xFFF0), no overflow; FrameEnd -> ResSum=65520, ResCount=16.
- Frame with 3,9,9,1 then FrameEnd, RdReady toggling 1,0,1,1,1 -> RdData sequence 9,9,3,1 with RdIdx 0..3; data held during the stall; ResValid is a single pulse.
- FrameEnd during DUMP -> ErrFrameDrop=1, dump output unchanged; the next FrameStart clears ErrFrameDrop.
- FrameStart+FrameEnd+DataEn(77) in one cycle, old list {50} -> snapshot {50}, new Count=1, DataMax=77.
- FrameEnd on empty frame -> ResValid pulse, ResCount=0, RdValid never rises.
